// File: rtl/memory_const.sv
// -----------------------------------------------------------------------------
// memory_const
// Shared encodings for the memory arbiter slice.
//   - Requester command codes (3 bits per port). Only READ and WRITE are
//     requests; NOP and every unused code are ignored by the arbiter.
//   - Arbiter FSM state encoding.
//   - cmd_is_pending(): decides whether a command code asks for service.
// -----------------------------------------------------------------------------
package memory_const;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    MEMORY_CMD_NOP   = 3'd0,
    MEMORY_CMD_READ  = 3'd1,
    MEMORY_CMD_WRITE = 3'd2
  } memory_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_READ = 2'd2
  } arb_state_e;

  function automatic logic cmd_is_pending(input logic [CMD_W-1:0] cmd);
    return (cmd == MEMORY_CMD_READ) || (cmd == MEMORY_CMD_WRITE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches upward from last_grant_i+1
// (wrapping modulo N) and picks the first pending requester.
// Ports:
//   pending_i    [N]      request vector
//   last_grant_i [IDX_W]  index of the most recently granted port
//   grant_o      [N]      one-hot grant (all zero when nothing pending)
//   grant_idx_o  [IDX_W]  index of the granted port
//   any_o                 at least one port pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  int cand;

  // The first hit wins; later candidates are masked by any_o.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant_i) + k) % N;
      if (!any_o && pending_i[IDX_W'(cand)]) begin
        any_o                 = 1'b1;
        grant_o[IDX_W'(cand)] = 1'b1;
        grant_idx_o           = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Round-robin arbiter letting NPORTS requesters share one memory command
// channel, with exactly one command in flight.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_cmd/addr/wdata/wmask  packed per-port command fields (port p at slice p)
//   req_ready                 one-hot acceptance strobe (combinational, IDLE only)
//   resp_valid                one-hot completion pulse
//   resp_rdata                shared read data, qualified by resp_valid
//   mem_cmd_start/write/ready memory command handshake
//   mem_addr/wdata/wmask      captured command fields toward memory
//   mem_rdata/mem_rdata_valid read return, honoured only in WAIT_READ
// -----------------------------------------------------------------------------
module memory_arbiter
  import memory_const::*;
#(
  parameter int NPORTS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS*CMD_W-1:0]  req_cmd,
  input  logic [NPORTS*ADDR_W-1:0] req_addr,
  input  logic [NPORTS*DATA_W-1:0] req_wdata,
  input  logic [NPORTS*DATA_W-1:0] req_wmask,
  output logic [NPORTS-1:0]        req_ready,
  output logic [NPORTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     mem_cmd_start,
  output logic                     mem_cmd_write,
  input  logic                     mem_cmd_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W-1:0]        mem_wmask,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rdata_valid
);

  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q;
  logic [NPORTS-1:0]  owner_q;          // one-hot port owning the in-flight command
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  wmask_q;
  logic [NPORTS-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  rdata_q;

  logic [NPORTS-1:0]  pending;
  logic [NPORTS-1:0]  grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               accept;
  logic               rdata_take;
  logic [CMD_W-1:0]   sel_cmd;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_pending
    assign pending[gi] = cmd_is_pending(req_cmd[gi*CMD_W +: CMD_W]);
  end

  rr_arbiter #(
    .N     (NPORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .pending_i    (pending),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .any_o        (grant_any)
  );

  assign sel_cmd = req_cmd[int'(grant_idx)*CMD_W +: CMD_W];

  always_comb begin
    state_d       = state_q;
    resp_valid_d  = '0;
    req_ready     = '0;
    mem_cmd_start = 1'b0;
    accept        = 1'b0;
    rdata_take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready = grant;
          accept    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_cmd_ready) begin
          mem_cmd_start = 1'b1;
          if (write_q) begin
            // Writes are acknowledged as soon as memory takes the command.
            resp_valid_d = owner_q;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_WAIT_READ;
          end
        end
      end
      ST_WAIT_READ: begin
        if (mem_rdata_valid) begin
          rdata_take   = 1'b1;
          resp_valid_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Strobes must stay quiet while reset is held, even if the state
    // register still holds a pre-reset value this cycle.
    if (rst) begin
      req_ready     = '0;
      mem_cmd_start = 1'b0;
      accept        = 1'b0;
      rdata_take    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NPORTS - 1);  // port 0 searched first
      owner_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      resp_valid_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      if (accept) begin
        last_grant_q <= grant_idx;
        owner_q      <= grant;
        write_q      <= (sel_cmd == MEMORY_CMD_WRITE);
        addr_q       <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        wdata_q      <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
        wmask_q      <= req_wmask[int'(grant_idx)*DATA_W +: DATA_W];
      end
      if (rdata_take) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = rdata_q;
  assign mem_cmd_write = write_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
// Four-port arbiter bench. A transaction-level reference (round-robin pointer,
// one outstanding command, expected response slot) predicts every strobe each
// cycle; directed sequences cover the named scenarios, then a random phase.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;
  import memory_const::*;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP*3-1:0]    req_cmd;
  logic [NP*AW-1:0]   req_addr;
  logic [NP*DW-1:0]   req_wdata;
  logic [NP*DW-1:0]   req_wmask;
  logic [NP-1:0]      req_ready;
  logic [NP-1:0]      resp_valid;
  logic [DW-1:0]      resp_rdata;
  logic               mem_cmd_start;
  logic               mem_cmd_write;
  logic               mem_cmd_ready;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_wmask;
  logic [DW-1:0]      mem_rdata;
  logic               mem_rdata_valid;

  always #5 clk = ~clk;

  memory_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_cmd         (req_cmd),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wmask       (req_wmask),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .mem_cmd_start   (mem_cmd_start),
    .mem_cmd_write   (mem_cmd_write),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wmask       (mem_wmask),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // requester-side stimulus
  logic [2:0]    r_cmd   [NP];
  logic [AW-1:0] r_addr  [NP];
  logic [DW-1:0] r_wdata [NP];
  logic [DW-1:0] r_wmask [NP];
  bit hold_req, auto_req;

  // memory-side stimulus
  bit            mem_ready_rand, mem_ready_v, spur_en, rdata_fix_en;
  int            mem_delay_fix, mem_cnt;
  logic [DW-1:0] rdata_fix;

  // reference model
  bit            m_free, m_wait_start, m_wait_data;
  int            m_last, m_port;
  logic [2:0]    m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_wmask, m_rdata;
  logic [NP-1:0] m_resp_due;
  int            grant_q[$];
  int            resp_count[NP];
  int            start_count;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cycle, got, exp);
    end
  endtask

  function automatic int gq(input int i);
    return (grant_q.size() > i) ? grant_q[i] : -1;
  endfunction

  task automatic new_req(input int p);
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)       r_cmd[p] = MEMORY_CMD_READ;
    else if (r < 8)  r_cmd[p] = MEMORY_CMD_WRITE;
    else if (r == 8) r_cmd[p] = MEMORY_CMD_NOP;
    else             r_cmd[p] = 3'($urandom_range(3, 7));
    r_addr[p]  = $urandom;
    r_wdata[p] = $urandom;
    r_wmask[p] = $urandom;
  endtask

  task automatic model_reset();
    m_free = 1; m_wait_start = 0; m_wait_data = 0;
    m_last = NP - 1; m_port = 0; m_cmd = '0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_rdata = '0;
    m_resp_due = '0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model.
  task automatic step();
    logic [NP-1:0] pend, exp_ready, exp_resp;
    logic          exp_start;
    int            g, c;
    for (int p = 0; p < NP; p++) begin
      req_cmd[3*p +: 3]     = r_cmd[p];
      req_addr[AW*p +: AW]  = r_addr[p];
      req_wdata[DW*p +: DW] = r_wdata[p];
      req_wmask[DW*p +: DW] = r_wmask[p];
    end
    mem_cmd_ready   = mem_ready_rand ? ($urandom_range(0, 3) != 0) : mem_ready_v;
    mem_rdata_valid = 1'b0;
    mem_rdata       = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_rdata_valid = 1'b1;
        if (rdata_fix_en) mem_rdata = rdata_fix;
      end
    end else if (spur_en && !m_wait_data && $urandom_range(0, 7) == 0) begin
      mem_rdata_valid = 1'b1;
    end

    @(negedge clk);
    pend = '0;
    for (int p = 0; p < NP; p++)
      pend[p] = (r_cmd[p] == MEMORY_CMD_READ) || (r_cmd[p] == MEMORY_CMD_WRITE);
    g = -1;
    if (!rst && m_free) begin
      for (int k = 1; k <= NP; k++) begin
        c = (m_last + k) % NP;
        if (g < 0 && pend[c]) g = c;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_start = !rst && m_wait_start && mem_cmd_ready;
    exp_resp  = m_resp_due;

    check_eq("req_ready",  64'(req_ready),     64'(exp_ready));
    check_eq("cmd_start",  64'(mem_cmd_start), 64'(exp_start));
    check_eq("resp_valid", 64'(resp_valid),    64'(exp_resp));
    check_eq("resp_rdata", 64'(resp_rdata),    64'(m_rdata));
    if (exp_start) begin
      check_eq("mem_addr",  64'(mem_addr),      64'(m_addr));
      check_eq("mem_wdata", 64'(mem_wdata),     64'(m_wdata));
      check_eq("mem_wmask", 64'(mem_wmask),     64'(m_wmask));
      check_eq("mem_write", 64'(mem_cmd_write), 64'(m_cmd == MEMORY_CMD_WRITE));
    end
    if (mem_cmd_start) start_count++;
    for (int p = 0; p < NP; p++) if (resp_valid[p]) resp_count[p]++;
    if (|resp_valid)
      $display("txn cycle %0d: port resp %b %s addr %h rdata %h", cycle, resp_valid,
               (m_cmd == MEMORY_CMD_WRITE) ? "WR" : "RD", m_addr, resp_rdata);

    m_resp_due = '0;
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      m_free = 0; m_wait_start = 1; m_port = g; m_last = g;
      m_cmd = r_cmd[g]; m_addr = r_addr[g]; m_wdata = r_wdata[g]; m_wmask = r_wmask[g];
      grant_q.push_back(g);
    end else if (exp_start) begin
      m_wait_start = 0;
      if (m_cmd == MEMORY_CMD_WRITE) begin
        m_resp_due[m_port] = 1'b1;
        m_free = 1;
      end else begin
        m_wait_data = 1;
        mem_cnt = (mem_delay_fix > 0) ? mem_delay_fix : $urandom_range(1, 4);
      end
    end else if (m_wait_data && mem_rdata_valid) begin
      m_wait_data = 0;
      m_resp_due[m_port] = 1'b1;
      m_rdata = mem_rdata;
      m_free = 1;
    end

    if (g >= 0 && !hold_req) begin
      if (auto_req) new_req(g);
      else r_cmd[g] = MEMORY_CMD_NOP;
    end
    if (auto_req) begin
      for (int p = 0; p < NP; p++)
        if (p != g && !pend[p] && $urandom_range(0, 3) == 0) new_req(p);
    end

    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < NP; p++) begin
      r_cmd[p] = MEMORY_CMD_NOP; r_addr[p] = '0; r_wdata[p] = '0; r_wmask[p] = '0;
    end
  endtask

  initial begin
    int s0, r0;
    rst = 1'b1;
    clear_reqs();
    hold_req = 0; auto_req = 0;
    mem_ready_rand = 0; mem_ready_v = 1; spur_en = 0;
    rdata_fix_en = 0; rdata_fix = '0; mem_delay_fix = 2; mem_cnt = 0;
    start_count = 0;
    for (int p = 0; p < NP; p++) resp_count[p] = 0;
    req_cmd = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    mem_cmd_ready = 1'b0; mem_rdata = '0; mem_rdata_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    apply_reset(1);
    check_eq("rst_mem_addr",  64'(mem_addr),      64'd0);
    check_eq("rst_mem_write", 64'(mem_cmd_write), 64'd0);
    check_eq("rst_mem_wmask", 64'(mem_wmask),     64'd0);

    // Single read on port 0, data two cycles after start.
    grant_q.delete();
    s0 = start_count; r0 = resp_count[0];
    rdata_fix_en = 1; rdata_fix = 32'hDEADBEEF;
    r_cmd[0] = MEMORY_CMD_READ; r_addr[0] = 32'h100;
    repeat (6) step();
    rdata_fix_en = 0;
    check_eq("rd_grant",  64'(gq(0)), 64'd0);
    check_eq("rd_rdata",  64'(resp_rdata), 64'hDEADBEEF);
    check_eq("rd_starts", 64'(start_count - s0), 64'd1);
    check_eq("rd_resps",  64'(resp_count[0] - r0), 64'd1);

    // Port 1 write stalled by mem_cmd_ready low for three cycles.
    grant_q.delete();
    s0 = start_count; r0 = resp_count[1];
    mem_ready_v = 0;
    r_cmd[1] = MEMORY_CMD_WRITE; r_addr[1] = 32'h200;
    r_wdata[1] = 32'h12345678; r_wmask[1] = 32'h0000FFFF;
    repeat (4) step();
    check_eq("wr_no_start", 64'(start_count - s0), 64'd0);
    mem_ready_v = 1;
    repeat (3) step();
    check_eq("wr_grant",  64'(gq(0)), 64'd1);
    check_eq("wr_starts", 64'(start_count - s0), 64'd1);
    check_eq("wr_resps",  64'(resp_count[1] - r0), 64'd1);

    // Ports 0 and 1 continuously pending after reset alternate.
    apply_reset(1);
    grant_q.delete();
    hold_req = 1;
    r_cmd[0] = MEMORY_CMD_READ;  r_addr[0] = 32'h40;
    r_cmd[1] = MEMORY_CMD_WRITE; r_addr[1] = 32'h80;
    mem_delay_fix = 1;
    repeat (20) step();
    for (int i = 0; i < 4; i++) check_eq($sformatf("alt_grant%0d", i), 64'(gq(i)), 64'(i % 2));
    clear_reqs();
    repeat (6) step();

    // Port 3 alone, then ports 0 and 3.
    apply_reset(1);
    grant_q.delete();
    r_cmd[3] = MEMORY_CMD_READ; r_addr[3] = 32'h300;
    for (int i = 0; i < 10 && grant_q.size() == 0; i++) step();
    r_cmd[0] = MEMORY_CMD_WRITE; r_addr[0] = 32'h10;
    repeat (16) step();
    check_eq("p3_first", 64'(gq(0)), 64'd3);
    check_eq("p0_next",  64'(gq(1)), 64'd0);
    check_eq("p3_again", 64'(gq(2)), 64'd3);
    hold_req = 0;
    clear_reqs();
    repeat (6) step();

    // Reset while waiting for read data; late data must be ignored.
    apply_reset(1);
    grant_q.delete();
    mem_delay_fix = 4;
    r0 = resp_count[1];
    r_cmd[1] = MEMORY_CMD_READ; r_addr[1] = 32'h500;
    repeat (3) step();
    apply_reset(2);
    grant_q.delete();
    r_cmd[0] = MEMORY_CMD_READ; r_addr[0] = 32'h600;
    r_cmd[1] = MEMORY_CMD_READ; r_addr[1] = 32'h700;
    repeat (16) step();
    check_eq("rst_abandon_grant", 64'(gq(0)), 64'd0);
    check_eq("rst_abandon_resp1", 64'(resp_count[1] - r0), 64'd1);

    // Random traffic, random memory stalls and stray read-valid pulses.
    clear_reqs();
    apply_reset(1);
    auto_req = 1; mem_ready_rand = 1; spur_en = 1; mem_delay_fix = 0;
    repeat (3000) step();
    check_eq("random_progress", 64'(grant_q.size() > 100), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
